// File: rtl/i2c_scl_gen_pkg.sv
// Shared types and defaults for the I2C SCL generator.
package i2c_scl_gen_pkg;

  // Default width of the prescale value and the quarter counter.
  localparam int PRESC_W_DEF = 8;

  // 3-bit state encoding of the SCL sequencer.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOW0    = 3'd1,
    ST_LOW1    = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_HIGH0   = 3'd4,
    ST_HIGH1   = 3'd5
  } scl_state_e;

  // Timed states are the four quarter-phases; IDLE and WAIT_HI hold the counter.
  function automatic logic is_timed(input scl_state_e st);
    return (st == ST_LOW0) || (st == ST_LOW1) || (st == ST_HIGH0) || (st == ST_HIGH1);
  endfunction

endpackage

// File: rtl/i2c_scl_gen_counter.sv
// Loadable up-counter used to time SCL quarter-phases.
module i2c_scl_gen_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Load has priority over counting; the count holds when not enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= data_i;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C SCL waveform generator with quarter-phase timing strobes.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | bus clock released, waiting for start_req
// LOW0     | first quarter of SCL low
// LOW1     | second quarter of SCL low (SDA may change on entry)
// WAIT_HI  | SCL released, waiting for synchronised SCL high (stretch)
// HIGH0    | first quarter of SCL high
// HIGH1    | second quarter of SCL high (SDA sampled on entry)
import i2c_scl_gen_pkg::*;

module i2c_scl_gen #(
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               asyn_rst,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               start_req,
  input  logic               stop_req,
  input  logic               scl_in,
  output logic               scl_oe,
  output logic               busy,
  output logic               stretching,
  output logic               tick_change,
  output logic               tick_rise,
  output logic               tick_sample,
  output logic               tick_fall
);

  scl_state_e         state_q, state_d;
  logic               scl_meta_q, scl_sync_q;
  logic               stop_pend_q, stop_pend_d;
  logic [PRESC_W-1:0] p_lat_q, p_lat_d;
  // ticks: [3]=change [2]=rise [1]=sample [0]=fall
  logic [3:0]         ticks_q, ticks_d;
  logic [PRESC_W-1:0] cnt;
  logic               timed;
  logic               qend;
  logic               state_entry;

  assign timed       = is_timed(state_q);
  assign qend        = timed && (cnt == p_lat_q);
  assign state_entry = (state_d != state_q);

  i2c_scl_gen_counter #(.W(PRESC_W)) u_qcnt (
    .clk_i   (clk),
    .rst_i   (asyn_rst),
    .load_i  (state_entry | qend),
    .en_i    (timed),
    .data_i  ('0),
    .count_o (cnt)
  );

  // Two-flop synchroniser for the raw bus level; resets to the idle-high level.
  always_ff @(posedge clk) begin
    if (asyn_rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;
      scl_sync_q <= scl_meta_q;
    end
  end

  // State, pending stop, latched prescale and strobe registers.
  always_ff @(posedge clk) begin
    if (asyn_rst) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
      p_lat_q     <= '0;
      ticks_q     <= '0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      p_lat_q     <= p_lat_d;
      ticks_q     <= ticks_d;
    end
  end

  // Next-state logic; a stop_req coinciding with the HIGH1 end takes effect at once.
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    p_lat_d     = p_lat_q;
    ticks_d     = 4'b0000;
    if (!enable) begin
      state_d     = ST_IDLE;
      stop_pend_d = 1'b0;
    end else begin
      if ((state_q != ST_IDLE) && stop_req) begin
        stop_pend_d = 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_req && !stop_req) begin
            state_d = ST_LOW0;
            p_lat_d = prescale;
          end
        end
        ST_LOW0: begin
          if (qend) begin
            state_d = ST_LOW1;
            ticks_d = 4'b1000;
          end
        end
        ST_LOW1: begin
          if (qend) begin
            state_d = ST_WAIT_HI;
            ticks_d = 4'b0100;
          end
        end
        ST_WAIT_HI: begin
          if (scl_sync_q) begin
            state_d = ST_HIGH0;
          end
        end
        ST_HIGH0: begin
          if (qend) begin
            state_d = ST_HIGH1;
            ticks_d = 4'b0010;
          end
        end
        ST_HIGH1: begin
          if (qend) begin
            if (stop_pend_q || stop_req) begin
              state_d     = ST_IDLE;
              stop_pend_d = 1'b0;
            end else begin
              state_d = ST_LOW0;
              ticks_d = 4'b0001;
            end
          end
        end
        default: begin
          state_d     = ST_IDLE;
          stop_pend_d = 1'b0;
        end
      endcase
    end
  end

  // SCL is pulled low exactly while in the two low quarters.
  assign scl_oe      = (state_q == ST_LOW0) || (state_q == ST_LOW1);
  assign busy        = (state_q != ST_IDLE);
  assign stretching  = (state_q == ST_WAIT_HI) && !scl_sync_q;
  assign tick_change = ticks_q[3];
  assign tick_rise   = ticks_q[2];
  assign tick_sample = ticks_q[1];
  assign tick_fall   = ticks_q[0];

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed scoreboard bench for the I2C SCL generator.
module tb_i2c_scl_gen;

  logic       clk;
  logic       asyn_rst;
  logic       enable;
  logic [7:0] prescale;
  logic       start_req;
  logic       stop_req;
  logic       scl_in;
  logic       scl_hold;
  logic       scl_oe, busy, stretching;
  logic       tick_change, tick_rise, tick_sample, tick_fall;
  logic [3:0] ticks, prev_ticks;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] kind;
    int         at;
  } ev_t;
  ev_t sb[$];

  i2c_scl_gen #(.PRESC_W(8)) dut (
    .clk         (clk),
    .asyn_rst    (asyn_rst),
    .enable      (enable),
    .prescale    (prescale),
    .start_req   (start_req),
    .stop_req    (stop_req),
    .scl_in      (scl_in),
    .scl_oe      (scl_oe),
    .busy        (busy),
    .stretching  (stretching),
    .tick_change (tick_change),
    .tick_rise   (tick_rise),
    .tick_sample (tick_sample),
    .tick_fall   (tick_fall)
  );

  // Open-drain bus: low when driven by the DUT or held by a stretching slave.
  assign scl_in = !scl_oe && !scl_hold;
  assign ticks  = {tick_change, tick_rise, tick_sample, tick_fall};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) step();
  endtask

  task automatic push(input logic [3:0] kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Expected strobes of one bit whose LOW0 is first visible at cycle e,
  // with x extra WAIT_HI cycles caused by stretching.
  task automatic push_bit(input int e, input int p, input int x, input bit stop);
    push(4'b1000, e + p + 1);
    push(4'b0100, e + 2*p + 2);
    push(4'b0010, e + 3*p + 6 + x);
    if (!stop) push(4'b0001, e + 4*p + 7 + x);
  endtask

  // Tick monitor: pops the scoreboard whenever a strobe appears.
  initial prev_ticks = 4'b0000;
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (ticks != 4'b0000) begin
      check("tick_onehot", int'($onehot(ticks)), 1);
      check("tick_width", int'(prev_ticks & ticks), 0);
      if (sb.size() == 0) begin
        check("tick_unexpected", int'(ticks), 0);
      end else begin
        e = sb.pop_front();
        check("tick_kind", int'(ticks), int'(e.kind));
        check("tick_cycle", cyc, e.at);
      end
    end
    prev_ticks = ticks;
  end

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_oe"}, int'(scl_oe), 0);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    int e, e2, n;
    asyn_rst = 1'b1; enable = 1'b1; prescale = 8'd3;
    start_req = 1'b0; stop_req = 1'b0; scl_hold = 1'b0;
    step(); step();
    check("rst_oe", int'(scl_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_stretch", int'(stretching), 0);
    check("rst_ticks", int'(ticks), 0);
    asyn_rst = 1'b0;
    step();

    // P=3: two bits, prescale change ignored, stop during LOW1 of the second bit
    prescale = 8'd3; start_req = 1'b1; e = cyc + 1;
    push_bit(e, 3, 0, 0);
    push_bit(e + 19, 3, 0, 1);
    step(); start_req = 1'b0;
    check("p3_oe_low0", int'(scl_oe), 1);
    check("p3_busy", int'(busy), 1);
    prescale = 8'd9;
    wait_cyc(e + 8);
    check("p3_oe_waithi", int'(scl_oe), 0);
    check("p3_stretch_sync", int'(stretching), 1);
    wait_cyc(e + 10);
    check("p3_stretch_end", int'(stretching), 0);
    e2 = e + 19;
    wait_cyc(e2 + 4);
    stop_req = 1'b1; step(); stop_req = 1'b0;
    wait_cyc(e2 + 19);
    check_idle("p3_stop");
    step(); step();

    // P=0: period 7, stop during LOW1 of the second bit
    prescale = 8'd0; start_req = 1'b1; e = cyc + 1;
    push_bit(e, 0, 0, 0);
    push_bit(e + 7, 0, 0, 1);
    step(); start_req = 1'b0;
    e2 = e + 7;
    wait_cyc(e2 + 1);
    stop_req = 1'b1; step(); stop_req = 1'b0;
    wait_cyc(e2 + 7);
    check_idle("p0_stop");
    step(); step();

    // P=3 with slave holding SCL low 20 clk after tick_rise
    prescale = 8'd3; scl_hold = 1'b1; start_req = 1'b1; e = cyc + 1;
    push_bit(e, 3, 20, 1);
    step(); start_req = 1'b0;
    wait_cyc(e + 4);
    stop_req = 1'b1; step(); stop_req = 1'b0;
    wait_cyc(e + 8);
    n = 0;
    while (cyc < e + 40) begin
      if (cyc == e + 28) scl_hold = 1'b0;
      if (stretching) n++;
      step();
    end
    check("stretch_cycles", n, 22);
    check_idle("stretch_stop");

    // stop_req and start_req together in IDLE: stays idle
    start_req = 1'b1; stop_req = 1'b1;
    step(); start_req = 1'b0; stop_req = 1'b0;
    check_idle("startstop_a");
    step();
    check_idle("startstop_b");

    // enable=0 during HIGH0
    prescale = 8'd3; start_req = 1'b1; e = cyc + 1;
    push(4'b1000, e + 4);
    push(4'b0100, e + 8);
    step(); start_req = 1'b0;
    wait_cyc(e + 12);
    enable = 1'b0; step();
    check_idle("dis_high0");
    check("dis_stretch", int'(stretching), 0);
    enable = 1'b1; step();

    // restart, then synchronous reset during LOW1
    start_req = 1'b1; e = cyc + 1;
    push(4'b1000, e + 4);
    step(); start_req = 1'b0;
    wait_cyc(e + 5);
    asyn_rst = 1'b1; step();
    check_idle("rst_low1");
    asyn_rst = 1'b0; step();

    // restart after reset runs full quarters
    prescale = 8'd3; start_req = 1'b1; e = cyc + 1;
    push_bit(e, 3, 0, 1);
    step(); start_req = 1'b0;
    check("restart_oe", int'(scl_oe), 1);
    wait_cyc(e + 4);
    stop_req = 1'b1; step(); stop_req = 1'b0;
    wait_cyc(e + 19);
    check_idle("restart_stop");
    step(); step(); step();
    check("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
